// File: rtl/fetch_stage.sv
// F stage of the 5-stage MIPS pipeline: holds PC_F, addresses instruction memory,
// flags fetch address errors and owns the F/D pipeline register that feeds decode.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_TOP   = 32'h0000_6FFC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush_d,
  input  logic [31:0]      npc,
  output logic [31:0]      i_inst_addr,
  input  logic [31:0]      i_inst_rdata,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic             valid_d,
  output logic             adel_d,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        adel;
  } fd_reg_t;

  logic [31:0]      pc_f_q, pc_f_d;
  fd_reg_t          fd_q, fd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        fetch_err;
  logic [31:0] fetch_word;

  // Misaligned or outside the instruction window; a faulting fetch enters D as a nop.
  assign fetch_err  = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IM_BASE) || (pc_f_q > IM_TOP);
  assign fetch_word = fetch_err ? 32'h0000_0000 : i_inst_rdata;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to remember it.
    pc_f_d = stall ? pc_f_q : npc;
    fd_d   = fd_q;
    cnt_d  = cnt_q;
    if (flush_d) begin
      // The bubble still records pc_f so decode knows where the slot came from.
      fd_d = '{instr: 32'h0000_0000, pc: pc_f_q, valid: 1'b0, adel: 1'b0};
    end else if (!stall) begin
      fd_d  = '{instr: fetch_word, pc: pc_f_q, valid: 1'b1, adel: fetch_err};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      pc_f_q <= PC_RESET;
      fd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pc_f_q <= pc_f_d;
      fd_q   <= fd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign i_inst_addr = pc_f_q;
  assign pc_f        = pc_f_q;
  assign instr_d     = fd_q.instr;
  assign pc_d        = fd_q.pc;
  assign valid_d     = fd_q.valid;
  assign adel_d      = fd_q.adel;
  assign fetch_cnt   = cnt_q;

endmodule
